// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arbState_t        : 2-bit FSM encoding (IDLE, FETCH_PEND, DATA_PEND)
//   STARVE_LIMIT_DEF  : default fetch starvation bound
//   ctrWidth()        : bits needed to hold a counter value 0..limit
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_PEND = 2'd1,
    DATA_PEND  = 2'd2
  } arbState_t;

  localparam int STARVE_LIMIT_DEF = 3;

  function automatic int ctrWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Fetch starvation counter. Counts consecutive cycles in which a fetch
// request was denied, saturating at STARVE_LIMIT; clears when the fetch
// is granted or withdrawn.
//   clk, reset : clock, synchronous active-low reset
//   ifReq      : fetch request this cycle
//   ifGnt      : fetch granted this cycle
//   starveQ    : current count
//   starved    : count has reached STARVE_LIMIT
module starve_ctr
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CW           = ctrWidth(STARVE_LIMIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifReq,
  input  logic          ifGnt,
  output logic [CW-1:0] starveQ,
  output logic          starved
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  assign starved = (starveQ == LIMIT);

  always_ff @(posedge clk) begin
    if (!reset)                starveQ <= '0;
    else if (ifGnt || !ifReq) starveQ <= '0;
    else if (!starved)         starveQ <= starveQ + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins over fetch unless the fetch has been denied STARVE_LIMIT
// cycles in a row. One access per cycle; grants and mem_* are
// combinational in the request cycle, read data returns one cycle later
// and is flagged by the rvalid of whichever side owned the access.
//   clk, reset          : clock, synchronous active-low reset
//   if_*                : fetch request / grant / read return
//   d_*                 : data request / grant / read return
//   mem_*               : single-port memory strobe and read data
//   stall_if, stall_mem : denied-request stalls to the hazard unit
// Optional build macro ARB_PERF_CNT_EN adds conflict_cnt and forced_cnt.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [31:0]     forced_cnt
`endif
);

  localparam int CW = ctrWidth(STARVE_LIMIT);

  arbState_t     state, stateNext;
  logic [CW-1:0] starveQ;
  logic          starved;
  logic          forceFetch;

  starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) uStarve (
    .clk     (clk),
    .reset   (reset),
    .ifReq   (if_req),
    .ifGnt   (if_gnt),
    .starveQ (starveQ),
    .starved (starved)
  );

  // Grants are held off for the whole reset cycle.
  assign forceFetch = if_req && starved;
  assign d_gnt      = reset && d_req && !forceFetch;
  assign if_gnt     = reset && if_req && (!d_req || forceFetch);

  assign stall_if  = if_req && !if_gnt;
  assign stall_mem = d_req && !d_gnt;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    stateNext = IDLE;
    if (d_gnt) begin
      mem_req   = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      stateNext = d_we ? IDLE : DATA_PEND;
    end else if (if_gnt) begin
      mem_req   = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
      stateNext = FETCH_PEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // An access outstanding when reset arrives is dropped: its return is
  // masked in the reset cycle, and the state is IDLE right after.
  assign if_rvalid = reset && (state == FETCH_PEND);
  assign d_rvalid  = reset && (state == DATA_PEND);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef ARB_PERF_CNT_EN
  logic conflictCyc, forcedGnt;
  logic [31:0] conflictCnt, forcedCnt;

  assign conflictCyc = if_req && d_req;
  // Forced only when data was also asking; a lone fetch wins anyway.
  assign forcedGnt   = if_gnt && d_req && starved;

  always_ff @(posedge clk) begin
    if (!reset) begin
      conflictCnt <= '0;
      forcedCnt   <= '0;
    end else begin
      if (conflictCyc) conflictCnt <= conflictCnt + 32'd1;
      if (forcedGnt)   forcedCnt   <= forcedCnt + 32'd1;
    end
  end

  assign conflict_cnt = conflictCnt;
  assign forced_cnt   = forcedCnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt, if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req, d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt, d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            mem_req, mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            stall_if, stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]     conflict_cnt, forced_cnt;
`endif

  int nRun = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
  );

  // Inputs change 1 time unit after the rising edge; checks happen 2 units
  // later, well clear of either edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idleInputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
    settle();
    nRun++;
    if ({if_gnt, d_gnt, mem_req, mem_we} !== 4'b0000) begin
      nFail++;
      $display("FAIL reset_hold: gnts/mem_req/mem_we=%b expected 0000",
               {if_gnt, d_gnt, mem_req, mem_we});
    end
    step();
    idleInputs();
    settle();
    nRun++;
    if ({if_rvalid, d_rvalid} !== 2'b00) begin
      nFail++;
      $display("FAIL reset_rvalid: rvalids=%b expected 00", {if_rvalid, d_rvalid});
    end
    reset = 1;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h0;
    settle();
    nRun++;
    if ({if_gnt, d_gnt, mem_req, mem_we, stall_if} !== 5'b10100 || mem_addr !== 32'h0
        || mem_be !== 4'hF) begin
      nFail++;
      $display("FAIL fetch_grant: gnt/dgnt/req/we/stall=%b addr=%h be=%h expected 10100 0 f",
               {if_gnt, d_gnt, mem_req, mem_we, stall_if}, mem_addr, mem_be);
    end
    step();
    if_req = 0; mem_rdata = 32'h00500093;
    settle();
    nRun++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin
      nFail++;
      $display("FAIL fetch_return: if_rvalid=%b d_rvalid=%b if_rdata=%h expected 1 0 00500093",
               if_rvalid, d_rvalid, if_rdata);
    end
    step();
    mem_rdata = '0;
    settle();
    nRun++;
    if ({if_rvalid, d_rvalid, mem_req} !== 3'b000) begin
      nFail++;
      $display("FAIL fetch_idle: if_rvalid/d_rvalid/mem_req=%b expected 000",
               {if_rvalid, d_rvalid, mem_req});
    end
  endtask

  task automatic test_conflict();
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    settle();
    nRun++;
    if ({d_gnt, if_gnt, stall_if, stall_mem, mem_we} !== 5'b10100 || mem_addr !== 32'h100) begin
      nFail++;
      $display("FAIL conflict_grant: dgnt/ignt/stif/stmem/we=%b addr=%h expected 10100 100",
               {d_gnt, if_gnt, stall_if, stall_mem, mem_we}, mem_addr);
    end
    step();
    idleInputs(); mem_rdata = 32'hCAFEF00D;
    settle();
    nRun++;
    if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
      nFail++;
      $display("FAIL conflict_return: d_rvalid=%b if_rvalid=%b d_rdata=%h expected 1 0 cafef00d",
               d_rvalid, if_rvalid, d_rdata);
    end
    step();
    mem_rdata = '0;
  endtask

  task automatic test_starve();
    logic [1:0] exp;
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      settle();
      exp = (i < 3) ? 2'b10 : 2'b01;
      nRun++;
      if ({d_gnt, if_gnt} !== exp || stall_mem !== exp[0] || stall_if !== exp[1]) begin
        nFail++;
        $display("FAIL starve_c%0d: dgnt/ignt=%b stall_if=%b stall_mem=%b expected %b",
                 i, {d_gnt, if_gnt}, stall_if, stall_mem, exp);
      end
      step();
    end
    // After the forced grant the counter restarts, so data wins again.
    settle();
    nRun++;
    if ({d_gnt, if_gnt, if_rvalid} !== 3'b101) begin
      nFail++;
      $display("FAIL starve_after: dgnt/ignt/if_rvalid=%b expected 101",
               {d_gnt, if_gnt, if_rvalid});
    end
    idleInputs();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h12345678;
    settle();
    nRun++;
    if ({d_gnt, mem_req, mem_we} !== 3'b111 || mem_be !== 4'hF || mem_addr !== 32'h200
        || mem_wdata !== 32'h12345678) begin
      nFail++;
      $display("FAIL b2b_write: gnt/req/we=%b be=%h addr=%h wdata=%h expected 111 f 200 12345678",
               {d_gnt, mem_req, mem_we}, mem_be, mem_addr, mem_wdata);
    end
    step();
    idleInputs(); if_req = 1; if_addr = 32'h4;
    settle();
    nRun++;
    if ({d_rvalid, if_gnt, mem_we} !== 3'b010 || mem_addr !== 32'h4) begin
      nFail++;
      $display("FAIL b2b_fetch: d_rvalid/ignt/we=%b addr=%h expected 010 4",
               {d_rvalid, if_gnt, mem_we}, mem_addr);
    end
    step();
    if_req = 0; mem_rdata = 32'h00A00113;
    settle();
    nRun++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h00A00113) begin
      nFail++;
      $display("FAIL b2b_return: if_rvalid=%b d_rvalid=%b if_rdata=%h expected 1 0 00a00113",
               if_rvalid, d_rvalid, if_rdata);
    end
    step();
    idleInputs();
  endtask

  task automatic test_no_grant();
    d_be = 4'hF; d_we = 1; d_addr = 32'h55;
    settle();
    nRun++;
    if ({mem_req, mem_we, if_gnt, d_gnt, stall_if, stall_mem} !== 6'b0 || mem_be !== 4'h0) begin
      nFail++;
      $display("FAIL no_grant: req/we/ignt/dgnt/stalls=%b be=%h expected 000000 0",
               {mem_req, mem_we, if_gnt, d_gnt, stall_if, stall_mem}, mem_be);
    end
    idleInputs();
    step();
  endtask

  task automatic test_reset_mid_read();
    // Both requests: data read granted, fetch denied so starve_q becomes 1.
    if_req = 1; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h180;
    settle();
    nRun++;
    if (d_gnt !== 1'b1) begin
      nFail++;
      $display("FAIL rst_read_grant: d_gnt=%b expected 1", d_gnt);
    end
    step();
    idleInputs(); reset = 0; mem_rdata = 32'hDEADBEEF;
    settle();
    nRun++;
    if (d_rvalid !== 1'b0 || dut.starveQ !== 2'd1) begin
      nFail++;
      $display("FAIL rst_read_drop: d_rvalid=%b starve_q=%0d expected 0 1", d_rvalid, dut.starveQ);
    end
    step();
    reset = 1;
    settle();
    nRun++;
    if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dut.state !== IDLE || dut.starveQ !== 2'd0) begin
      nFail++;
      $display("FAIL rst_read_after: d_rvalid=%b if_rvalid=%b state=%0d starve_q=%0d expected 0 0 0 0",
               d_rvalid, if_rvalid, dut.state, dut.starveQ);
    end
    mem_rdata = '0;
    step();
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset = 0;
    step();
    reset = 1;
    if_req = 1; d_req = 1; d_we = 0;
    for (int i = 0; i < 5; i++) step();
    idleInputs();
    settle();
    nRun++;
    // Cycles 0-2 data, cycle 3 forced fetch, cycle 4 data: one forced grant.
    if (conflict_cnt !== 32'd5 || forced_cnt !== 32'd1) begin
      nFail++;
      $display("FAIL perf_cnt: conflict=%0d forced=%0d expected 5 1", conflict_cnt, forced_cnt);
    end
    step();
    force dut.conflictCnt = 32'hFFFFFFFF;
    #1;
    release dut.conflictCnt;
    if_req = 1; d_req = 1;
    step();
    idleInputs();
    settle();
    nRun++;
    if (conflict_cnt !== 32'd0) begin
      nFail++;
      $display("FAIL perf_wrap: conflict=%h expected 00000000", conflict_cnt);
    end
    step();
  endtask
`endif

  initial begin
    reset = 0;
    idleInputs();
    step();
    test_reset();
    test_fetch();
    test_conflict();
    test_starve();
    test_back_to_back();
    test_no_grant();
    test_reset_mid_read();
`ifdef ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
